// File: rtl/pcie_ts_rx.sv
// pcie_ts_rx
// Receive-side TS1/TS2 ordered-set decoder for one PCIe lane.
// Finds a COM (K28.5), checks the 16-symbol ordered set, and reports the
// decoded fields together with a count of consecutive identical ordered sets.
//
// Ports
//   clk_i, rst_i     : clock, synchronous active-high reset
//   sym_i, sym_k_i   : decoded symbol and its K (control) flag
//   sym_valid_i      : symbol strobe; the parser holds its state while low
//   ts_valid_o       : one-cycle pulse for a complete, well-formed TS
//   ts_type_o        : 0 = TS1, 1 = TS2
//   link_num_o       : {PAD, link number}
//   lane_num_o       : {PAD, lane number}
//   n_fts_o, rate_o, train_ctl_o : remaining TS fields
//   ts_consec_o      : consecutive identical TS count, saturates at 15
//   consec_met_o     : ts_consec_o >= CONSEC_TARGET
//   ts_err_o         : one-cycle pulse for a malformed or aborted TS
module pcie_ts_rx #(
  parameter logic [7:0] COM_SYM       = 8'hBC,
  parameter logic [7:0] PAD_SYM       = 8'hF7,
  parameter logic [7:0] TS1_ID        = 8'h4A,
  parameter logic [7:0] TS2_ID        = 8'h45,
  parameter int         CONSEC_TARGET = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] sym_i,
  input  logic       sym_k_i,
  input  logic       sym_valid_i,
  output logic       ts_valid_o,
  output logic       ts_type_o,
  output logic [8:0] link_num_o,
  output logic [8:0] lane_num_o,
  output logic [7:0] n_fts_o,
  output logic [7:0] rate_o,
  output logic [7:0] train_ctl_o,
  output logic [3:0] ts_consec_o,
  output logic       consec_met_o,
  output logic       ts_err_o
);

  localparam logic [3:0] TARGET4 = 4'(CONSEC_TARGET);

  typedef enum logic [1:0] {ST_HUNT, ST_FIELDS, ST_IDENT} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_idx, w_idx_next;

  // shadow copy of the TS being received
  logic       r_type_sh;
  logic [8:0] r_link_sh, r_lane_sh;
  logic [7:0] r_nfts_sh, r_rate_sh, r_ctl_sh;

  // reported copy
  logic       r_valid, r_err, r_type, r_met;
  logic [8:0] r_link, r_lane;
  logic [7:0] r_nfts, r_rate, r_ctl;
  logic [3:0] r_consec;

  logic       w_com, w_pad, w_sym_ok, w_err, w_done, w_clr_sh, w_cap, w_same;
  logic [7:0] w_exp_id;
  logic [3:0] w_cnt_next;

  assign w_com    = sym_k_i && (sym_i == COM_SYM);
  assign w_pad    = sym_k_i && (sym_i == PAD_SYM);
  assign w_exp_id = r_type_sh ? TS2_ID : TS1_ID;

  // Is the symbol at the current index acceptable?
  always_comb begin
    w_sym_ok = 1'b0;
    case (r_idx)
      4'd1, 4'd2:       w_sym_ok = !sym_k_i || w_pad;
      4'd3, 4'd4, 4'd5: w_sym_ok = !sym_k_i;
      4'd6:             w_sym_ok = !sym_k_i && ((sym_i == TS1_ID) || (sym_i == TS2_ID));
      4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
      4'd12, 4'd13, 4'd14, 4'd15:
                        w_sym_ok = !sym_k_i && (sym_i == w_exp_id);
      default:          w_sym_ok = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_err        = 1'b0;
    w_done       = 1'b0;
    w_clr_sh     = 1'b0;
    w_cap        = 1'b0;
    if (sym_valid_i) begin
      case (r_state)
        ST_HUNT: begin
          if (w_com) begin
            w_clr_sh     = 1'b1;
            w_idx_next   = 4'd1;
            w_state_next = ST_FIELDS;
          end
        end
        ST_FIELDS, ST_IDENT: begin
          if (w_com) begin
            // a COM mid-TS aborts it and is itself symbol 0 of a new TS
            w_err        = 1'b1;
            w_clr_sh     = 1'b1;
            w_idx_next   = 4'd1;
            w_state_next = ST_FIELDS;
          end else if (w_sym_ok) begin
            w_cap = 1'b1;
            if (r_idx == 4'd15) begin
              w_done       = 1'b1;
              w_idx_next   = 4'd0;
              w_state_next = ST_HUNT;
            end else begin
              w_idx_next = r_idx + 4'd1;
              if (r_idx == 4'd5) w_state_next = ST_IDENT;
            end
          end else begin
            w_err        = 1'b1;
            w_idx_next   = 4'd0;
            w_state_next = ST_HUNT;
          end
        end
        default: begin
          w_idx_next   = 4'd0;
          w_state_next = ST_HUNT;
        end
      endcase
    end
  end

  // Consecutive-identical count
  assign w_same = ({r_type_sh, r_link_sh, r_lane_sh, r_nfts_sh, r_rate_sh, r_ctl_sh} ==
                   {r_type,    r_link,    r_lane,    r_nfts,    r_rate,    r_ctl});

  always_comb begin
    w_cnt_next = r_consec;
    if (w_err) begin
      w_cnt_next = 4'd0;
    end else if (w_done) begin
      if (w_same && (r_consec != 4'd0))
        w_cnt_next = (r_consec == 4'd15) ? 4'd15 : r_consec + 4'd1;
      else
        w_cnt_next = 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_HUNT;
      r_idx     <= 4'd0;
      r_type_sh <= 1'b0;
      r_link_sh <= 9'd0;
      r_lane_sh <= 9'd0;
      r_nfts_sh <= 8'd0;
      r_rate_sh <= 8'd0;
      r_ctl_sh  <= 8'd0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_type    <= 1'b0;
      r_link    <= 9'd0;
      r_lane    <= 9'd0;
      r_nfts    <= 8'd0;
      r_rate    <= 8'd0;
      r_ctl     <= 8'd0;
      r_consec  <= 4'd0;
      r_met     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_idx    <= w_idx_next;
      r_valid  <= w_done;
      r_err    <= w_err;
      r_consec <= w_cnt_next;
      r_met    <= (w_cnt_next >= TARGET4);

      if (w_clr_sh) begin
        r_type_sh <= 1'b0;
        r_link_sh <= 9'd0;
        r_lane_sh <= 9'd0;
        r_nfts_sh <= 8'd0;
        r_rate_sh <= 8'd0;
        r_ctl_sh  <= 8'd0;
      end else if (w_cap) begin
        case (r_idx)
          4'd1:    r_link_sh <= w_pad ? 9'h100 : {1'b0, sym_i};
          4'd2:    r_lane_sh <= w_pad ? 9'h100 : {1'b0, sym_i};
          4'd3:    r_nfts_sh <= sym_i;
          4'd4:    r_rate_sh <= sym_i;
          4'd5:    r_ctl_sh  <= sym_i;
          4'd6:    r_type_sh <= (sym_i == TS2_ID);
          default: ;
        endcase
      end

      if (w_done) begin
        r_type <= r_type_sh;
        r_link <= r_link_sh;
        r_lane <= r_lane_sh;
        r_nfts <= r_nfts_sh;
        r_rate <= r_rate_sh;
        r_ctl  <= r_ctl_sh;
      end
    end
  end

  assign ts_valid_o   = r_valid;
  assign ts_err_o     = r_err;
  assign ts_type_o    = r_type;
  assign link_num_o   = r_link;
  assign lane_num_o   = r_lane;
  assign n_fts_o      = r_nfts;
  assign rate_o       = r_rate;
  assign train_ctl_o  = r_ctl;
  assign ts_consec_o  = r_consec;
  assign consec_met_o = r_met;

endmodule

// File: tb/tb_pcie_ts_rx.sv
// Directed testbench for pcie_ts_rx.
module tb_pcie_ts_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sym;
  logic       sym_k;
  logic       sym_valid;
  logic       ts_valid, ts_type, consec_met, ts_err;
  logic [8:0] link_num, lane_num;
  logic [7:0] n_fts, rate, train_ctl;
  logic [3:0] ts_consec;

  pcie_ts_rx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sym_i        (sym),
    .sym_k_i      (sym_k),
    .sym_valid_i  (sym_valid),
    .ts_valid_o   (ts_valid),
    .ts_type_o    (ts_type),
    .link_num_o   (link_num),
    .lane_num_o   (lane_num),
    .n_fts_o      (n_fts),
    .rate_o       (rate),
    .train_ctl_o  (train_ctl),
    .ts_consec_o  (ts_consec),
    .consec_met_o (consec_met),
    .ts_err_o     (ts_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // monitor state
  int         n_valid = 0;
  int         n_err   = 0;
  int         n_both  = 0;
  int         last_err_cyc = -1;
  int         v_cyc  [0:127];
  logic [3:0] v_cons [0:127];
  logic       v_met  [0:127];

  // driver bookkeeping
  int drv_cyc, bad_cyc, com_cyc, last_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (ts_valid && n_valid < 128) begin
      v_cyc[n_valid]  = cyc;
      v_cons[n_valid] = ts_consec;
      v_met[n_valid]  = consec_met;
      n_valid++;
    end
    if (ts_err) begin
      n_err++;
      last_err_cyc = cyc;
    end
    if (ts_valid && ts_err) n_both++;
  end

  task automatic put_sym(input logic [7:0] s, input logic k, input bit gaps);
    if (gaps) begin
      int g;
      g = 0;
      // stall cycles carry a COM on the bus to prove it is ignored
      while (g < 3 && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        sym_valid = 1'b0;
        sym       = 8'hBC;
        sym_k     = 1'b1;
        g++;
      end
    end
    @(negedge clk);
    sym       = s;
    sym_k     = k;
    sym_valid = 1'b1;
    drv_cyc   = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_valid = 1'b0;
      sym       = 8'h00;
      sym_k     = 1'b0;
    end
  endtask

  task automatic send_ts(input bit t2, input logic [8:0] link, input logic [8:0] lane,
                         input logic [7:0] nfts, input logic [7:0] rt, input logic [7:0] ctl,
                         input int bad_idx, input logic [7:0] bad_s, input logic bad_k,
                         input int n_sym, input bit gaps);
    logic [7:0] s;
    logic       k;
    for (int i = 0; i < n_sym; i++) begin
      k = 1'b0;
      if (i == 0)      begin s = 8'hBC; k = 1'b1; end
      else if (i == 1) begin s = link[8] ? 8'hF7 : link[7:0]; k = link[8]; end
      else if (i == 2) begin s = lane[8] ? 8'hF7 : lane[7:0]; k = lane[8]; end
      else if (i == 3) s = nfts;
      else if (i == 4) s = rt;
      else if (i == 5) s = ctl;
      else             s = t2 ? 8'h45 : 8'h4A;
      if (i == bad_idx) begin s = bad_s; k = bad_k; end
      put_sym(s, k, gaps);
      if (i == bad_idx) bad_cyc = drv_cyc;
      if (i == 0) com_cyc = drv_cyc;
      last_cyc = drv_cyc;
    end
    $display("tx TS%0d link=%h lane=%h nfts=%h rate=%h ctl=%h bad_idx=%0d syms=%0d gaps=%0d",
             t2 ? 2 : 1, link, lane, nfts, rt, ctl, bad_idx, n_sym, gaps);
  endtask

  initial begin
    int nv0, ne0;
    rst = 1'b1; sym = 8'h00; sym_k = 1'b0; sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {ts_valid, ts_type, link_num, lane_num, n_fts, rate, train_ctl, ts_consec, consec_met, ts_err},
             64'd0);
    rst = 1'b0;
    idle(2);

    // 1: eight back-to-back TS1, PAD/PAD
    nv0 = n_valid;
    for (int t = 0; t < 8; t++) send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 16, 0);
    idle(2);
    check_eq("b2b_count", 64'(n_valid - nv0), 64'd8);
    for (int t = 0; t < 8; t++) check_eq($sformatf("b2b_consec%0d", t), 64'(v_cons[nv0 + t]), 64'(t + 1));
    check_eq("b2b_met7", 64'(v_met[nv0 + 6]), 64'd0);
    check_eq("b2b_met8", 64'(v_met[nv0 + 7]), 64'd1);
    check_eq("b2b_spacing", 64'(v_cyc[nv0 + 1] - v_cyc[nv0]), 64'd16);
    check_eq("b2b_span", 64'(v_cyc[nv0 + 7] - v_cyc[nv0]), 64'd112);
    check_eq("b2b_latency", 64'(v_cyc[nv0 + 7]), 64'(last_cyc + 1));
    check_eq("b2b_fields", {ts_type, link_num, lane_num, n_fts, rate, train_ctl},
             {1'b0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00});

    // 2: four more TS1 then a TS2 with link 5
    nv0 = n_valid;
    for (int t = 0; t < 4; t++) send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 16, 0);
    send_ts(1, 9'h005, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 16, 0);
    idle(2);
    check_eq("ts1_run_consec12", 64'(v_cons[nv0 + 3]), 64'd12);
    check_eq("ts2_type", 64'(ts_type), 64'd1);
    check_eq("ts2_link", 64'(link_num), 64'h005);
    check_eq("ts2_consec", 64'(ts_consec), 64'd1);
    check_eq("ts2_met", 64'(consec_met), 64'd0);

    // 3: identifier symbol 11 corrupted
    nv0 = n_valid; ne0 = n_err;
    send_ts(1, 9'h005, 9'h100, 8'h20, 8'h02, 8'h00, 11, 8'h4B, 1'b0, 16, 0);
    idle(2);
    check_eq("bad_id_err", 64'(n_err - ne0), 64'd1);
    check_eq("bad_id_err_time", 64'(last_err_cyc), 64'(bad_cyc + 1));
    check_eq("bad_id_novalid", 64'(n_valid - nv0), 64'd0);
    check_eq("bad_id_consec", 64'(ts_consec), 64'd0);
    check_eq("bad_id_hold_link", 64'(link_num), 64'h005);
    send_ts(1, 9'h005, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 16, 0);
    idle(2);
    check_eq("after_err_consec", 64'(ts_consec), 64'd1);

    // non-PAD K symbol in the link field
    ne0 = n_err;
    send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, 1, 8'h1C, 1'b1, 16, 0);
    idle(2);
    check_eq("k_field_err", 64'(n_err - ne0), 64'd1);
    check_eq("k_field_err_time", 64'(last_err_cyc), 64'(bad_cyc + 1));
    check_eq("k_field_consec", 64'(ts_consec), 64'd0);

    // 4: COM injected at index 9 starts a new good TS1
    nv0 = n_valid; ne0 = n_err;
    send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 9, 0);
    send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 16, 0);
    idle(2);
    check_eq("abort_err", 64'(n_err - ne0), 64'd1);
    check_eq("abort_err_time", 64'(last_err_cyc), 64'(com_cyc + 1));
    check_eq("abort_valid", 64'(n_valid - nv0), 64'd1);
    check_eq("abort_valid_time", 64'(v_cyc[nv0]), 64'(com_cyc + 16));
    check_eq("abort_report", {ts_type, link_num, ts_consec}, {1'b0, 9'h100, 4'd1});

    // 5: twenty identical TS2 with random stalls
    nv0 = n_valid; ne0 = n_err;
    for (int t = 0; t < 20; t++) send_ts(1, 9'h005, 9'h003, 8'h40, 8'h04, 8'h01, -1, 8'h00, 1'b0, 16, 1);
    idle(2);
    check_eq("stall_count", 64'(n_valid - nv0), 64'd20);
    check_eq("stall_noerr", 64'(n_err - ne0), 64'd0);
    check_eq("stall_first", 64'(v_cons[nv0]), 64'd1);
    check_eq("stall_15th", 64'(v_cons[nv0 + 14]), 64'd15);
    check_eq("stall_sat", 64'(ts_consec), 64'd15);
    check_eq("stall_met", 64'(consec_met), 64'd1);
    check_eq("stall_fields", {ts_type, link_num, lane_num, n_fts, rate, train_ctl},
             {1'b1, 9'h005, 9'h003, 8'h40, 8'h04, 8'h01});

    // 6: reset asserted at index 4
    send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 4, 0);
    @(negedge clk);
    sym = 8'h02; sym_k = 1'b0; sym_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_eq("midreset_outputs",
             {ts_valid, ts_type, link_num, lane_num, n_fts, rate, train_ctl, ts_consec, consec_met, ts_err},
             64'd0);
    rst = 1'b0; sym_valid = 1'b0;
    nv0 = n_valid;
    send_ts(0, 9'h100, 9'h100, 8'h20, 8'h02, 8'h00, -1, 8'h00, 1'b0, 16, 0);
    idle(2);
    check_eq("post_reset_valid", 64'(n_valid - nv0), 64'd1);
    check_eq("post_reset_report", {ts_type, link_num, n_fts, ts_consec}, {1'b0, 9'h100, 8'h20, 4'd1});

    check_eq("valid_err_exclusive", 64'(n_both), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_ts_rx.md
# pcie_ts_rx

Receive-side training-sequence decoder for the PCIe physical layer. Consumes the 8b/10b-decoded symbol stream of one lane, delineates TS1/TS2 ordered sets, validates their format and reports decoded fields plus a consecutive-identical count. The `pcie_controller` LTSSM uses these reports to advance Polling/Configuration. This block is the receiving end of the training sequences the controller transmits.

## Interface
- `COM_SYM`, default 8'hBC: K28.5 comma, with K flag set.
- `PAD_SYM`, default 8'hF7: K23.7 PAD, with K flag set.
- `TS1_ID`, default 8'h4A: D10.2 TS1 identifier.
- `TS2_ID`, default 8'h45: D5.2 TS2 identifier.
- `CONSEC_TARGET`, default 8: identical-TS count that raises `consec_met_o`. Legal range is 1–15.
- `clk_i` in 1: single clock for the whole block.
- `rst_i` in 1: synchronous, active-high reset.
- `sym_i` in 8: decoded symbol.
- `sym_k_i` in 1: symbol is a K (control) code.
- `sym_valid_i` in 1: `sym_i`/`sym_k_i` valid this cycle. When low, the parser stalls with no state change.
- `ts_valid_o` out 1: one-cycle pulse when a complete, well-formed TS has been decoded.
- `ts_type_o` out 1: 0 = TS1, 1 = TS2.
- `link_num_o` out 9: bit 8 = PAD, bits 7:0 = link number (0 when PAD).
- `lane_num_o` out 9: same encoding as `link_num_o`, for the lane number.
- `n_fts_o` out 8: N_FTS field.
- `rate_o` out 8: data-rate identifier.
- `train_ctl_o` out 8: training-control field.
- `ts_consec_o` out 4: count of consecutive identical TSs, saturating at 15.
- `consec_met_o` out 1: `ts_consec_o >= CONSEC_TARGET`.
- `ts_err_o` out 1: one-cycle pulse on a malformed or aborted TS.

## Operation
- A TS is 16 symbols, indexed 0–15:
  - 0: COM.
  - 1: link number or PAD.
  - 2: lane number or PAD.
  - 3: N_FTS.
  - 4: rate.
  - 5: training control.
  - 6–15: identifier. All ten must equal one ID, either TS1_ID or TS2_ID.
- Only cycles with `sym_valid_i` high count as symbols.
- FSM states:
  - **HUNT**: discards symbols until COM arrives with K=1. Then clears the field shadows, sets index = 1 and moves to FIELDS.
  - **FIELDS** (index 1–5): captures into shadow registers.
    - Indices 1–2 accept either a data symbol, or PAD with K=1 (stored with bit 8 set). Any other K symbol is an error.
    - Indices 3–5 must be data (K=0); otherwise error.
    - After index 5, go to IDENT.
  - **IDENT** (index 6–15):
    - Index 6 must be data equal to TS1_ID or TS2_ID; latch the type.
    - Indices 7–15 must be data equal to the latched ID.
    - After index 15 is accepted, the TS is complete: go to HUNT.
- Any error → pulse `ts_err_o`, clear `ts_consec_o` to 0, go to HUNT.
- COM with K=1 received in FIELDS or IDENT:
  - Abort the current TS and pulse `ts_err_o`.
  - Clear `ts_consec_o` to 0.
  - Treat the COM as symbol 0 of a new TS: index = 1, state FIELDS.
- On completion, compare the shadow tuple {type, link, lane, n_fts, rate, ctl} with the last reported tuple:
  - If equal and count ≠ 0: count = min(count+1, 15).
  - Otherwise: count = 1.
- Then copy the shadow tuple to the outputs.
- Reported outputs hold until the next completion or reset. They do not change on an error, except `ts_consec_o` and `consec_met_o`.
- Reset values: state HUNT, index 0, every output 0.

## Timing
- `ts_valid_o`, the field outputs, `ts_consec_o` and `consec_met_o` all update on the clock edge after index 15 is sampled. Latency is 1 cycle from the last identifier symbol.
- `ts_err_o` asserts one cycle after the offending symbol is sampled.
- `ts_valid_o` and `ts_err_o` are never high in the same cycle.
- Back-to-back TSs need no gap: a COM immediately after index 15 is accepted from HUNT on the same cycle that `ts_valid_o` pulses.
- Stalls (`sym_valid_i` low) at any index are tolerated indefinitely and do not abort a TS.
- `rst_i` asserted mid-TS: the partial TS is discarded. Next cycle all outputs are 0 and the FSM is in HUNT.

## Test plan
- Eight back-to-back TS1 (link PAD, lane PAD, n_fts 8'h20, rate 8'h02, ctl 0) → eight `ts_valid_o` pulses spaced 16 cycles apart. `ts_consec_o` reads 1..8, `consec_met_o` rises with the 8th, `link_num_o` = 9'h100.
- Four TS1 followed by one TS2 with link 8'h05 → the TS2 report has `ts_type_o` = 1, `link_num_o` = 9'h005, `ts_consec_o` = 1.
- Identifier symbol 11 corrupted to 8'h4B → `ts_err_o` pulses one cycle later, no `ts_valid_o`, `ts_consec_o` = 0. The next good TS reports count 1.
- COM injected at index 9, followed by a full good TS → one `ts_err_o`, then `ts_valid_o` 16 symbols after that COM.
- Random `sym_valid_i` deassertion (~50 %) across 20 identical TS2 → 20 `ts_valid_o` pulses; `ts_consec_o` saturates at 15.
- `rst_i` pulsed at index 4 → all outputs 0 the following cycle; a subsequent good TS yields count 1.
